// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the cycle sequencer: state codes,
// defaults, counter width and the latched decode bundle.
package cycle_sequencer_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;
  localparam logic [2:0] ST_FAULT  = 3'd7;

  localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;
  localparam int         MEM_TIMEOUT_DEF = 15;
  localparam int         ICNT_W          = 16;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic cond;
  } dec_t;

  function automatic logic st_busy(
    input logic [2:0] s
  );
    return (s >= ST_FETCH) && (s <= ST_WB);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM cycles spent without mem_ready.
// Ports: clk, reset (sync, high), clear (hold at zero),
//        inc (count this cycle), hit (count reaches
//        MEM_TIMEOUT at the coming edge).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic hit
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Flag the cycle whose increment lands on the limit,
  // so the owner leaves after exactly MEM_TIMEOUT cycles.
  assign hit = inc && !clear && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer for a small CPU.
// Ports: clk, reset (sync, high), run, step, opcode,
//        dec_* decode bits, zero, mem_ready in; ir_load,
//        pc_en, pc_jump_sel, reg_we, mem_req, mem_we,
//        busy, halted, state, instr_count out.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int         MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic [3:0]        opcode,
  input  logic              dec_reg_write,
  input  logic              dec_mem_write,
  input  logic              dec_mem_read,
  input  logic              dec_cond,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              ir_load,
  output logic              pc_en,
  output logic              pc_jump_sel,
  output logic              reg_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic              busy,
  output logic              halted,
  output logic [2:0]        state,
  output logic [ICNT_W-1:0] instr_count
);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  dec_t              dec_q;
  dec_t              dec_d;
  logic [ICNT_W-1:0] instr_count_q;
  logic [ICNT_W-1:0] instr_count_d;

  logic retire;
  logic tmo_hit;
  logic in_mem;
  logic mem_op;

  assign in_mem = (state_q == ST_MEM);
  assign mem_op = dec_q.mem_read || dec_q.mem_write;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (!in_mem),
    .inc   (in_mem && !mem_ready),
    .hit   (tmo_hit)
  );

  // Output decode: registered state and latched bits,
  // qualified only by the datapath flags zero/mem_ready.
  always_comb begin
    ir_load     = 1'b0;
    retire      = 1'b0;
    pc_jump_sel = 1'b0;
    reg_we      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    halted      = 1'b0;
    busy        = 1'b0;
    if (!reset) begin
      busy = st_busy(state_q);
      unique case (state_q)
        ST_FETCH: begin
          ir_load = 1'b1;
        end
        ST_EXEC: begin
          if (!mem_op && !dec_q.reg_write) begin
            retire      = 1'b1;
            pc_jump_sel = dec_q.cond && zero;
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = dec_q.mem_write;
          // mem_read selects load data, so it wins.
          if (mem_ready && !dec_q.mem_read) begin
            retire = 1'b1;
          end
        end
        ST_WB: begin
          reg_we = 1'b1;
          retire = 1'b1;
        end
        ST_HALT,
        ST_FAULT: begin
          halted = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign pc_en = retire;

  // Next-state process.
  always_comb begin
    state_d       = state_q;
    dec_d         = dec_q;
    instr_count_d = instr_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run || step) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        dec_d.reg_write = dec_reg_write;
        dec_d.mem_write = dec_mem_write;
        dec_d.mem_read  = dec_mem_read;
        dec_d.cond      = dec_cond;
        if (opcode == HALT_OPCODE) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (mem_op) begin
          state_d = ST_MEM;
        end else if (dec_q.reg_write) begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (dec_q.mem_read) begin
            state_d = ST_WB;
          end
        end else if (tmo_hit) begin
          state_d = ST_FAULT;
        end
      end
      default: begin
      end
    endcase
    if (retire) begin
      instr_count_d = instr_count_q + ICNT_W'(1);
      state_d       = run ? ST_FETCH : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      dec_q         <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      dec_q         <= dec_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: per-cycle vector
// table plus fault, halt, reset and wrap sequences.
module tb_cycle_sequencer;

  localparam int IR = 128;
  localparam int PC = 64;
  localparam int JS = 32;
  localparam int WE = 16;
  localparam int MQ = 8;
  localparam int MW = 4;
  localparam int BZ = 2;
  localparam int HL = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        step;
  logic [3:0]  opcode;
  logic        dec_reg_write;
  logic        dec_mem_write;
  logic        dec_mem_read;
  logic        dec_cond;
  logic        zero;
  logic        mem_ready;
  logic        ir_load;
  logic        pc_en;
  logic        pc_jump_sel;
  logic        reg_we;
  logic        mem_req;
  logic        mem_we;
  logic        busy;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cycle_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .step          (step),
    .opcode        (opcode),
    .dec_reg_write (dec_reg_write),
    .dec_mem_write (dec_mem_write),
    .dec_mem_read  (dec_mem_read),
    .dec_cond      (dec_cond),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .ir_load       (ir_load),
    .pc_en         (pc_en),
    .pc_jump_sel   (pc_jump_sel),
    .reg_we        (reg_we),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .busy          (busy),
    .halted        (halted),
    .state         (state),
    .instr_count   (instr_count)
  );

  typedef struct {
    logic       run;
    logic       step;
    logic [3:0] op;
    logic [3:0] d;
    logic       z;
    logic       rd;
    int         eo;
    int         cnt;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t mk(
    input int r, input int s, input int op,
    input int d, input int z, input int rd,
    input int st, input int fl, input int cnt
  );
    vec_t v;
    v.run  = r[0];
    v.step = s[0];
    v.op   = op[3:0];
    v.d    = d[3:0];
    v.z    = z[0];
    v.rd   = rd[0];
    v.eo   = (st << 8) | fl;
    v.cnt  = cnt;
    return v;
  endfunction

  function automatic int eo(input int st, input int fl);
    return (st << 8) | fl;
  endfunction

  function automatic int obs();
    return {21'b0, state, ir_load, pc_en, pc_jump_sel,
            reg_we, mem_req, mem_we, busy, halted};
  endfunction

  function automatic int cnt();
    return {16'b0, instr_count};
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    run  = v.run;
    step = v.step;
    opcode = v.op;
    {dec_reg_write, dec_mem_write,
     dec_mem_read, dec_cond} = v.d;
    zero      = v.z;
    mem_ready = v.rd;
  endtask

  task automatic idle_in();
    run = 0; step = 0; opcode = 0;
    dec_reg_write = 0; dec_mem_write = 0;
    dec_mem_read = 0; dec_cond = 0;
    zero = 0; mem_ready = 0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int mq_ok;
    // d = {reg_write, mem_write, mem_read, cond}
    vecs[0]  = mk(0,1,0,4'b0000,0,0, 0,0,0);
    vecs[1]  = mk(0,0,0,4'b0000,0,0, 1,IR|BZ,0);
    vecs[2]  = mk(0,0,1,4'b1000,0,0, 2,BZ,0);
    vecs[3]  = mk(0,0,0,4'b0000,0,0, 3,BZ,0);
    vecs[4]  = mk(0,0,0,4'b0000,0,0, 5,WE|PC|BZ,0);
    vecs[5]  = mk(0,0,0,4'b0000,0,0, 0,0,1);
    vecs[6]  = mk(1,0,0,4'b0000,0,0, 0,0,1);
    vecs[7]  = mk(1,0,0,4'b0000,0,0, 1,IR|BZ,1);
    vecs[8]  = mk(1,0,2,4'b0001,0,0, 2,BZ,1);
    vecs[9]  = mk(1,0,0,4'b0000,1,0, 3,PC|JS|BZ,1);
    vecs[10] = mk(1,0,0,4'b0000,0,0, 1,IR|BZ,2);
    vecs[11] = mk(1,0,3,4'b0001,0,0, 2,BZ,2);
    vecs[12] = mk(1,0,0,4'b0000,0,0, 3,PC|BZ,2);
    vecs[13] = mk(0,0,0,4'b0000,0,0, 1,IR|BZ,3);
    vecs[14] = mk(0,0,4,4'b1010,0,0, 2,BZ,3);
    vecs[15] = mk(0,0,0,4'b0000,0,0, 3,BZ,3);
    vecs[16] = mk(0,0,0,4'b0000,0,0, 4,MQ|BZ,3);
    vecs[17] = mk(0,0,0,4'b0000,0,0, 4,MQ|BZ,3);
    vecs[18] = mk(0,0,0,4'b0000,0,1, 4,MQ|BZ,3);
    vecs[19] = mk(0,0,0,4'b0000,0,0, 5,WE|PC|BZ,3);
    vecs[20] = mk(0,1,0,4'b0000,0,0, 0,0,4);
    vecs[21] = mk(0,1,0,4'b0000,0,0, 1,IR|BZ,4);
    vecs[22] = mk(0,1,5,4'b0100,0,0, 2,BZ,4);
    vecs[23] = mk(0,1,0,4'b0000,0,0, 3,BZ,4);
    vecs[24] = mk(0,1,0,4'b0000,0,1, 4,MQ|MW|PC|BZ,4);
    vecs[25] = mk(0,1,0,4'b0000,0,0, 0,0,5);
    vecs[26] = mk(0,1,0,4'b0000,0,0, 1,IR|BZ,5);
    vecs[27] = mk(0,0,6,4'b0000,0,0, 2,BZ,5);
    vecs[28] = mk(0,0,0,4'b0000,1,0, 3,PC|BZ,5);
    vecs[29] = mk(0,0,0,4'b0000,0,0, 0,0,6);
    vecs[30] = mk(0,0,0,4'b0000,0,0, 0,0,6);

    reset = 1;
    idle_in();
    tick();
    tick();
    chk("reset_out", obs(), eo(0, 0));
    chk("reset_cnt", cnt(), 0);
    reset = 0;

    for (int i = 0; i < 31; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d_out", i), obs(), vecs[i].eo);
      chk($sformatf("vec%0d_cnt", i), cnt(), vecs[i].cnt);
      tick();
    end

    // Store that never completes.
    idle_in();
    step = 1;
    tick();
    step = 0;
    tick();
    opcode = 4'h7;
    dec_mem_write = 1;
    tick();
    dec_mem_write = 0;
    opcode = 0;
    tick();
    n = 0;
    mq_ok = 1;
    while (state == 3'd4 && n < 40) begin
      if (!(mem_req && mem_we)) mq_ok = 0;
      n++;
      tick();
    end
    chk("fault_mem_cycles", n, 15);
    chk("fault_mem_req_held", mq_ok, 1);
    chk("fault_out", obs(), eo(7, HL));
    chk("fault_cnt", cnt(), 6);
    run = 1;
    step = 1;
    repeat (3) tick();
    chk("fault_absorb", obs(), eo(7, HL));

    reset = 1;
    #1;
    chk("reset_gates_out", obs(), eo(7, 0));
    tick();
    reset = 0;
    idle_in();
    #1;
    chk("fault_reset_out", obs(), eo(0, 0));
    chk("fault_reset_cnt", cnt(), 0);

    // Reset while a store is waiting in MEM.
    step = 1;
    tick();
    step = 0;
    tick();
    dec_mem_write = 1;
    tick();
    dec_mem_write = 0;
    tick();
    chk("mid_mem_req", obs(), eo(4, MQ|MW|BZ));
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("mid_mem_reset", obs(), eo(0, 0));

    // Retire one nop under run, then halt.
    run = 1;
    tick();
    opcode = 4'h6;
    tick();
    tick();
    chk("pre_halt_exec", obs(), eo(3, PC|BZ));
    tick();
    opcode = 4'hF;
    tick();
    chk("halt_decode", obs(), eo(2, BZ));
    tick();
    chk("halt_out", obs(), eo(6, HL));
    chk("halt_cnt", cnt(), 1);
    step = 1;
    repeat (3) tick();
    chk("halt_absorb", obs(), eo(6, HL));
    reset = 1;
    tick();
    reset = 0;
    idle_in();
    #1;
    chk("halt_reset_out", obs(), eo(0, 0));
    chk("halt_reset_cnt", cnt(), 0);

    // Counter wrap from all-ones.
    force dut.instr_count_q = 16'hFFFF;
    tick();
    release dut.instr_count_q;
    step = 1;
    tick();
    step = 0;
    opcode = 4'h1;
    tick();
    opcode = 4'h0;
    tick();
    chk("wrap_exec", obs(), eo(3, PC|BZ));
    tick();
    chk("wrap_out", obs(), eo(0, 0));
    chk("wrap_cnt", cnt(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 Parameter HALT_OPCODE, default 4'hF: opcode that stops the machine.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum MEM-state cycles without mem_ready before fault.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 run  input  1  level; 1 = free-run instructions back to back.
REQ-006 step  input  1  execute exactly one instruction; sampled in IDLE only.
REQ-007 opcode  input  4  instruction[15:12] from instruction ROM.
REQ-008 dec_reg_write, dec_mem_write, dec_mem_read, dec_cond  input  1 each  decoder outputs; dec_mem_read is the c_data select.
REQ-009 zero  input  1  ALU zero flag.
REQ-010 mem_ready  input  1  data RAM completion, one-cycle pulse.
REQ-011 ir_load  output  1  latch instruction register.
REQ-012 pc_en  output  1  advance PC this cycle.
REQ-013 pc_jump_sel  output  1  PC takes the jump target when pc_en=1.
REQ-014 reg_we  output  1  register file write enable.
REQ-015 mem_req, mem_we  output  1 each  RAM request, RAM write qualifier.
REQ-016 busy, halted  output  1 each  status.
REQ-017 state  output  3  current state code.
REQ-018 instr_count  output  16  retired-instruction counter.

Function
REQ-019 States, with codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
REQ-020 IDLE: go to FETCH if run=1 or step=1; otherwise stay in IDLE.
REQ-021 FETCH: ir_load=1 for one cycle, then go to DECODE.
REQ-022 DECODE: latch dec_* bits into internal registers; if opcode==HALT_OPCODE go to HALT, else go to EXEC.
REQ-023 EXEC, memory op (latched mem_read or mem_write): go to MEM.
REQ-024 EXEC, latched reg_write: go to WB.
REQ-025 EXEC, otherwise: retire, with pc_jump_sel = latched cond AND zero.
REQ-026 MEM: mem_req=1 and mem_we=latched mem_write, both held until mem_ready=1 is sampled.
REQ-027 MEM on mem_ready: a store retires; a load goes to WB.
REQ-028 MEM timeout: wait counter starts at 0 on MEM entry and increments each cycle without mem_ready; when it reaches MEM_TIMEOUT, go to FAULT.
REQ-029 WB: reg_we=1 for one cycle, then retire.
REQ-030 Retire cycle: pc_en=1 and instr_count+1; instr_count wraps 16'hFFFF to 0.
REQ-031 After retire: go to FETCH if run=1, else to IDLE.
REQ-032 pc_jump_sel shall be 0 on every cycle except a branch retire.
REQ-033 Latency in cycles, N = MEM cycles (N>=1): ALU op 4; branch/nop 3; store 3+N; load 4+N.
REQ-034 run falling mid-instruction: finish the instruction, then go to IDLE.
REQ-035 step while run=1 is ignored.
REQ-036 step held high in IDLE starts one instruction per IDLE visit.
REQ-037 HALT and FAULT: absorbing until reset; halted=1; all enables 0.
REQ-038 busy=1 in states FETCH through WB only.
REQ-039 All outputs are functions of the registered state and latched decode bits only; no combinational path from run or step to any output.

Reset
REQ-040 reset=1 at a clock edge: state=IDLE, instr_count=0, latched decode bits=0, wait counter=0.
REQ-041 In reset: ir_load, pc_en, pc_jump_sel, reg_we, mem_req, mem_we, busy and halted are all 0.
REQ-042 reset overrides every state, including MEM mid-request; mem_req shall be 0 in the cycle after the reset edge.

Structure
REQ-043 Shared package holds: the state encoding constants, the HALT_OPCODE default and the instr_count width (16).
REQ-044 One sub-module, mem_wait_timer: clear-on-entry counter with a terminal flag at MEM_TIMEOUT.
REQ-045 Everything else is a single next-state process plus a single output-decode process.

Verification
REQ-046 Reset, then step=1 for 1 cycle with an ALU op (reg_write=1) -> states 1,2,3,5,0; reg_we high exactly 1 cycle; instr_count=1.
REQ-047 run=1, branch with cond=1, zero=1 -> pc_en=pc_jump_sel=1 in the EXEC cycle; FETCH follows immediately.
REQ-048 Load with mem_ready arriving after 3 MEM cycles -> mem_req high for 3 cycles, mem_we=0, then WB; 7 cycles total.
REQ-049 Store with mem_ready never asserted, MEM_TIMEOUT=15 -> FAULT after 15 MEM cycles; halted=1; instr_count unchanged.
REQ-050 opcode=4'hF under run -> HALT after DECODE; stays in HALT with run=1; reset returns to IDLE with instr_count=0.
REQ-051 Preload instr_count=16'hFFFF by 65535 retires, then one more retire -> instr_count=0.
